// File: rtl/spram_rr_ctrl.sv
// spram_rr_ctrl: shares one single-port RAM between requesters A and B.
// Round-robin arbitration, one access per cycle, read data one cycle after
// the accepted read. Optionally zero-fills the RAM after reset.
//
// Handshake: a request from X transfers in any cycle where X_valid and
// X_ready are both high. X_ready is only ever high together with X_valid.
// A requester that sees X_ready low keeps its request (valid, wren, addr,
// data) stable until it is accepted. A read accepted in cycle t yields
// X_rvalid=1 in cycle t+1 only, with rdata carrying the result.
module spram_rr_ctrl #(
  parameter int AWIDTH         = 11,
  parameter int NUM_WORDS      = 2048,
  parameter int DWIDTH         = 60,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_wren,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_data,
  output logic              a_rvalid,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wren,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_data,
  output logic              b_rvalid,
  output logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH-1:0] mem_address,
  output logic              mem_wren,
  output logic [DWIDTH-1:0] mem_data,
  input  logic [DWIDTH-1:0] mem_out,
  output logic              init_done
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

  state_t            state;
  state_t            state_next;
  logic [AWIDTH-1:0] clr_cnt;
  logic              ptr_b;       // 0: A has priority on contention, 1: B
  logic              gnt_a;
  logic              gnt_b;
  logic              a_rvalid_q;
  logic              b_rvalid_q;

  // State register; reset selects whether the sweep runs at all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
    end else begin
      state <= state_next;
    end
  end

  // Clear sweep address: restarts at 0 on every reset, steps once per CLEAR cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Priority pointer hands priority to the other side after each grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_b <= 1'b0;
    end else if (gnt_a) begin
      ptr_b <= 1'b1;
    end else if (gnt_b) begin
      ptr_b <= 1'b0;
    end
  end

  // Read-response flags, one cycle behind the accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= gnt_a & ~a_wren;
      b_rvalid_q <= gnt_b & ~b_wren;
    end
  end

  // Next state, arbitration and RAM pin drive; everything idles while reset is high.
  always_comb begin
    state_next  = state;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    if (!reset) begin
      case (state)
        CLEAR: begin
          mem_wren    = 1'b1;
          mem_address = clr_cnt;
          if (clr_cnt == LAST_ADDR) begin
            state_next = RUN;
          end
        end
        RUN: begin
          gnt_a = a_valid & (~b_valid | ~ptr_b);
          gnt_b = b_valid & (~a_valid | ptr_b);
          if (gnt_a) begin
            mem_address = a_addr;
            mem_wren    = a_wren;
            mem_data    = a_data;
          end else if (gnt_b) begin
            mem_address = b_addr;
            mem_wren    = b_wren;
            mem_data    = b_data;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  assign a_ready   = gnt_a;
  assign b_ready   = gnt_b;
  assign a_rvalid  = a_rvalid_q & ~reset;
  assign b_rvalid  = b_rvalid_q & ~reset;
  assign rdata     = mem_out;
  assign init_done = (state == RUN) & ~reset;

endmodule

// File: tb/tb_spram_rr_ctrl.sv
// Bench for spram_rr_ctrl: one instance with the reset-time clear, one without,
// each in front of a behavioural single-port RAM with a registered output.
module tb_spram_rr_ctrl;
  localparam int AW = 11;
  localparam int DW = 60;
  localparam int NW = 2048;

  localparam logic [DW-1:0] D0 = 60'h123456789ABCDEF;
  localparam logic [DW-1:0] D1 = 60'h111222233334444;
  localparam logic [DW-1:0] D2 = 60'hFEDCBA987654321;
  localparam logic [DW-1:0] D3 = 60'h0F0F0F0F0F0F0F0;
  localparam logic [DW-1:0] D4 = 60'hABCDEF012345678;
  localparam logic [DW-1:0] D5 = 60'h5A5A5A5A5A5A5A5;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 0: clear on reset ----------------
  logic          reset;
  logic          a_valid, a_ready, a_wren, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid, b_ready, b_wren, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [DW-1:0] rdata, mem_data, mem_out;
  logic [AW-1:0] mem_address;
  logic          mem_wren, init_done;

  spram_rr_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_wren(a_wren), .a_addr(a_addr),
    .a_data(a_data), .a_rvalid(a_rvalid),
    .b_valid(b_valid), .b_ready(b_ready), .b_wren(b_wren), .b_addr(b_addr),
    .b_data(b_data), .b_rvalid(b_rvalid),
    .rdata(rdata), .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_out(mem_out), .init_done(init_done)
  );

  logic [DW-1:0] ram0 [0:NW-1] = '{default: '1};
  initial mem_out = '0;
  always @(posedge clk) begin
    if (mem_wren) ram0[mem_address] <= mem_data;
    else          mem_out <= ram0[mem_address];
  end

  // ---------------- instance 1: no clear ----------------
  logic          z_reset;
  logic          z_a_valid, z_a_ready, z_a_wren, z_a_rvalid;
  logic [AW-1:0] z_a_addr;
  logic [DW-1:0] z_a_data;
  logic          z_b_valid, z_b_ready, z_b_wren, z_b_rvalid;
  logic [AW-1:0] z_b_addr;
  logic [DW-1:0] z_b_data;
  logic [DW-1:0] z_rdata, z_mem_data, z_mem_out;
  logic [AW-1:0] z_mem_address;
  logic          z_mem_wren, z_init_done;

  spram_rr_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .reset(z_reset),
    .a_valid(z_a_valid), .a_ready(z_a_ready), .a_wren(z_a_wren), .a_addr(z_a_addr),
    .a_data(z_a_data), .a_rvalid(z_a_rvalid),
    .b_valid(z_b_valid), .b_ready(z_b_ready), .b_wren(z_b_wren), .b_addr(z_b_addr),
    .b_data(z_b_data), .b_rvalid(z_b_rvalid),
    .rdata(z_rdata), .mem_address(z_mem_address), .mem_wren(z_mem_wren),
    .mem_data(z_mem_data), .mem_out(z_mem_out), .init_done(z_init_done)
  );

  logic [DW-1:0] ram1 [0:NW-1] = '{default: '1};
  initial z_mem_out = '0;
  always @(posedge clk) begin
    if (z_mem_wren) ram1[z_mem_address] <= z_mem_data;
    else            z_mem_out <= ram1[z_mem_address];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic start_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive0(input logic av, input logic aw, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input logic bv, input logic bw,
                        input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_valid = av; a_wren = aw; a_addr = aa; a_data = ad;
    b_valid = bv; b_wren = bw; b_addr = ba; b_data = bd;
  endtask

  // Runs n sweep cycles from the current counter value start; returns count of bad cycles.
  task automatic sweep_check(input int start, input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      start_cycle();
      reset = 1'b0;
      drive0(1'b1, 1'b0, 11'h7FF, '0, 1'b0, 1'b0, '0, '0);
      #1;
      if (mem_wren !== 1'b1 || mem_address !== AW'(start + i) || mem_data !== '0 ||
          a_ready !== 1'b0 || b_ready !== 1'b0 || init_done !== 1'b0)
        bad++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          av, aw;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv, bw;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ea_rdy, eb_rdy, e_wren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          ea_rv, eb_rv, chk_rd;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int bad;
    // av aw aa  ad  bv bw ba  bd | a_rdy b_rdy wren addr data | a_rv b_rv chk rdata
    tbl[0]  = '{1,1,5,D0, 0,0,0,0,  1,0,1,5,D0,  1,0,1,'0}; // prior 0x7FF read returns 0
    tbl[1]  = '{1,0,5,0,  0,0,0,0,  1,0,0,5,0,   0,0,0,'0};
    tbl[2]  = '{0,0,0,0,  0,0,0,0,  0,0,0,0,0,   1,0,1,D0}; // write then read returns new data
    tbl[3]  = '{0,0,0,0,  1,1,1,D1, 0,1,1,1,D1,  0,0,0,'0};
    tbl[4]  = '{1,1,2,D2, 0,0,0,0,  1,0,1,2,D2,  0,0,0,'0};
    tbl[5]  = '{0,0,0,0,  1,0,2,0,  0,1,0,2,0,   0,0,0,'0}; // B alone once
    tbl[6]  = '{1,0,1,0,  1,0,2,0,  1,0,0,1,0,   0,1,1,D2}; // both: A wins first
    tbl[7]  = '{1,0,1,0,  1,0,2,0,  0,1,0,2,0,   1,0,1,D1};
    tbl[8]  = '{1,0,1,0,  1,0,2,0,  1,0,0,1,0,   0,1,1,D2};
    tbl[9]  = '{1,0,1,0,  1,0,2,0,  0,1,0,2,0,   1,0,1,D1};
    tbl[10] = '{0,0,0,0,  0,0,0,0,  0,0,0,0,0,   0,1,1,D2};
    tbl[11] = '{0,0,0,0,  1,0,1,0,  0,1,0,1,0,   0,0,0,'0}; // B alone repeatedly
    tbl[12] = '{0,0,0,0,  1,0,2,0,  0,1,0,2,0,   0,1,1,D1};
    tbl[13] = '{0,0,0,0,  1,1,3,D3, 0,1,1,3,D3,  0,1,1,D2};
    tbl[14] = '{1,1,7,D4, 0,0,0,0,  1,0,1,7,D4,  0,0,0,'0};
    tbl[15] = '{0,0,0,0,  1,0,7,0,  0,1,0,7,0,   0,0,0,'0};
    tbl[16] = '{0,0,0,0,  0,0,0,0,  0,0,0,0,0,   0,1,1,D4};

    // ---- reset, instance 0; A requests throughout ----
    reset = 1'b1;
    z_reset = 1'b1;
    z_a_valid = 0; z_a_wren = 0; z_a_addr = '0; z_a_data = '0;
    z_b_valid = 0; z_b_wren = 0; z_b_addr = '0; z_b_data = '0;
    drive0(1'b1, 1'b0, 11'h7FF, '0, 1'b1, 1'b0, 11'h001, '0);
    repeat (3) start_cycle();
    #1;
    check("rst_a_ready",   a_ready,   0);
    check("rst_b_ready",   b_ready,   0);
    check("rst_a_rvalid",  a_rvalid,  0);
    check("rst_b_rvalid",  b_rvalid,  0);
    check("rst_mem_wren",  mem_wren,  0);
    check("rst_init_done", init_done, 0);

    // ---- full clear sweep ----
    sweep_check(0, NW, bad);
    check("clear_sweep_bad_cycles", bad, 0);

    // cycle 2048: in RUN, A's held read of 0x7FF is accepted
    start_cycle();
    #1;
    check("init_done_rise", init_done, 1);
    check("run0_a_ready",   a_ready,   1);
    check("run0_mem_wren",  mem_wren,  0);
    check("run0_mem_addr",  mem_address, 11'h7FF);

    // ---- table-driven RUN traffic ----
    for (int i = 0; i < 17; i++) begin
      start_cycle();
      drive0(tbl[i].av, tbl[i].aw, tbl[i].aa, tbl[i].ad,
             tbl[i].bv, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      #1;
      check($sformatf("v%0d_a_ready", i),  a_ready,     tbl[i].ea_rdy);
      check($sformatf("v%0d_b_ready", i),  b_ready,     tbl[i].eb_rdy);
      check($sformatf("v%0d_mem_wren", i), mem_wren,    tbl[i].e_wren);
      check($sformatf("v%0d_mem_addr", i), mem_address, tbl[i].e_addr);
      check($sformatf("v%0d_mem_data", i), mem_data,    tbl[i].e_data);
      check($sformatf("v%0d_a_rvalid", i), a_rvalid,    tbl[i].ea_rv);
      check($sformatf("v%0d_b_rvalid", i), b_rvalid,    tbl[i].eb_rv);
      if (tbl[i].chk_rd) check($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
    end

    // ---- reset the cycle after an A read ----
    start_cycle();
    drive0(1'b1, 1'b0, 11'd5, '0, 1'b0, 1'b0, '0, '0);
    #1;
    check("midrun_read_a_ready", a_ready, 1);
    start_cycle();
    reset = 1'b1;
    #1;
    check("midrun_rst_a_rvalid",  a_rvalid,  0);
    check("midrun_rst_a_ready",   a_ready,   0);
    check("midrun_rst_init_done", init_done, 0);
    check("midrun_rst_mem_wren",  mem_wren,  0);

    // ---- sweep restarts at 0; reset again at counter 1000 ----
    sweep_check(0, 1000, bad);
    check("sweep_partial_bad_cycles", bad, 0);
    check("sweep_partial_a_rvalid", a_rvalid, 0);
    start_cycle();
    reset = 1'b1;
    #1;
    check("midsweep_rst_mem_wren",  mem_wren,  0);
    check("midsweep_rst_init_done", init_done, 0);
    sweep_check(0, NW, bad);
    check("resweep_bad_cycles", bad, 0);

    // ---- after resweep: addr 5 reads back zero ----
    start_cycle();
    drive0(1'b1, 1'b0, 11'd5, '0, 1'b0, 1'b0, '0, '0);
    #1;
    check("resweep_init_done", init_done, 1);
    check("resweep_a_ready",   a_ready,   1);
    start_cycle();
    drive0(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    check("resweep_a_rvalid", a_rvalid, 1);
    check("resweep_rdata",    rdata,    0);
    check("resweep_b_rvalid", b_rvalid, 0);

    // ---- instance 1: no clear ----
    start_cycle();
    z_a_valid = 1'b1;
    #1;
    check("z_rst_init_done", z_init_done, 0);
    check("z_rst_a_ready",   z_a_ready,   0);
    start_cycle();
    z_reset = 1'b0;
    z_a_valid = 1'b1; z_a_wren = 1'b1; z_a_addr = 11'd9; z_a_data = D5;
    #1;
    check("z_first_init_done", z_init_done, 1);
    check("z_first_a_ready",   z_a_ready,   1);
    check("z_first_mem_wren",  z_mem_wren,  1);
    check("z_first_mem_addr",  z_mem_address, 11'd9);
    check("z_first_mem_data",  z_mem_data,  D5);
    start_cycle();
    z_a_valid = 1'b0; z_a_wren = 1'b0; z_a_addr = '0; z_a_data = '0;
    #1;
    check("z_idle_mem_wren", z_mem_wren,    0);
    check("z_idle_mem_addr", z_mem_address, 0);
    check("z_idle_a_ready",  z_a_ready,     0);
    start_cycle();
    z_a_valid = 1'b1; z_a_addr = 11'd9;
    #1;
    check("z_read_a_ready", z_a_ready, 1);
    start_cycle();
    z_a_valid = 1'b0;
    #1;
    check("z_read_a_rvalid", z_a_rvalid, 1);
    check("z_read_rdata",    z_rdata,    D5);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spram_rr_ctrl.md
Name: spram_rr_ctrl

Overview:
- Controller that shares one single-port 2048x60 RAM between two requesters, A and B.
- It sits directly in front of the RAM instance and drives its address, write-enable and data pins.
- Arbitration is round-robin, one access per cycle, with valid/ready request handshakes and read responses one cycle later.
- After reset it optionally zero-fills the whole RAM before accepting any traffic.

Parameters:
- AWIDTH, 11, RAM address width.
- NUM_WORDS, 2048, RAM depth; also the clear sweep length.
- DWIDTH, 60, RAM data width.
- CLEAR_ON_RESET, 1; 1 = zero-fill the RAM after reset, 0 = go straight to RUN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request is accepted this cycle.
- a_wren  in  1  1 = write, 0 = read.
- a_addr  in  AWIDTH  A address.
- a_data  in  DWIDTH  A write data.
- a_rvalid  out  1  rdata holds A's read result.
- b_valid, b_ready, b_wren, b_addr, b_data, b_rvalid  same as A, for requester B.
- rdata  out  DWIDTH  read data; equals mem_out, qualified by a_rvalid or b_rvalid.
- mem_address  out  AWIDTH  to RAM address pin.
- mem_wren  out  1  to RAM write-enable pin.
- mem_data  out  DWIDTH  to RAM data pin.
- mem_out  in  DWIDTH  from RAM output register; 1-cycle read latency; holds its value on write cycles.
- init_done  out  1  high once the controller is in RUN.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- During reset:
  - a_ready=b_ready=0, a_rvalid=b_rvalid=0, mem_wren=0, init_done=0.
  - Clear counter=0; priority pointer=A.
- FSM states: CLEAR, RUN. First cycle after reset deasserts: CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR state:
  - mem_wren=1, mem_data=0, mem_address=counter; counter increments every cycle.
  - a_ready=b_ready=0.
  - Move to RUN after the cycle that writes NUM_WORDS-1.
  - The sweep is exactly NUM_WORDS cycles; init_done is 1 from the next cycle onward.
- RUN state, grant (combinational in the current cycle):
  - Neither valid: no grant; mem_wren=0, mem_address=0, mem_data=0.
  - Only one valid: grant it.
  - Both valid: grant the pointer side.
- RUN state, granted requester X:
  - X_ready=1.
  - mem_address=X_addr, mem_wren=X_wren, mem_data=X_data.
  - Pointer becomes the other side at the clock edge.
  - With no grant, the pointer is unchanged.
- Ready rules:
  - The losing side's ready=0; it must hold its request stable until ready.
  - ready never asserts without the matching valid.
- Read response:
  - A read accepted from X in cycle t gives X_rvalid=1 in cycle t+1 only, with rdata=mem_out.
  - Accepted writes produce no response.
  - a_rvalid and b_rvalid are never high together.
  - rvalid is a register reset to 0.
- Back-to-back:
  - A new access may be granted in the same cycle as a previous read's rvalid.
  - Write then read of the same address in consecutive accepted cycles returns the new data.
- Ordering: accesses complete in grant order; there are no hazards beyond those of the RAM itself.
- Reset mid-operation:
  - Mid-CLEAR or mid-RUN: the pending rvalid is dropped and the counter restarts at 0.
  - The sweep is redone from address 0.
- Address width: no address checking; AWIDTH bits pass straight to the RAM.

Test Plan:
- Reset release with CLEAR_ON_RESET=1:
  - Stimulus: release reset; hold a_valid=1 throughout.
  - mem_wren=1 for exactly 2048 cycles, addresses 0..2047, data 0.
  - a_ready=0 throughout; init_done rises at cycle 2048.
  - Then read addr 0x7FF → rdata=0.
- Single-requester traffic:
  - Stimulus: A writes 0x123456789ABCDEF to addr 5, then reads addr 5.
  - Required: a_ready=1 in both cycles; a_rvalid=1 one cycle after the read with rdata=0x123456789ABCDEF; b_rvalid stays 0.
- Contention:
  - Stimulus: A and B both issue continuous reads (A addr 1, B addr 2) starting immediately after init.
  - Grants alternate A,B,A,B…; rvalids alternate, one cycle behind.
  - rdata matches the preloaded contents of addrs 1 and 2.
- Pointer fairness:
  - Stimulus: B alone is granted once; then A and B both request.
  - Required: A wins first.
  - Stimulus: B alone repeatedly. Required: granted every cycle.
- Reset mid-sweep and mid-RUN:
  - Stimulus: assert reset at clear counter=1000.
  - Required: the sweep restarts at 0 and init_done stays 0 for 2048 cycles.
  - Stimulus: assert reset the cycle after an A read. Required: a_rvalid=0.
- CLEAR_ON_RESET=0:
  - init_done=1 on the first cycle after reset.
  - The first request is accepted immediately; mem_wren=0 when idle.
